pb_mcast_unroller: RTL and testbench
====================================

# pb_mcast_unroller

Sequencer that turns one multicast request (address plus X/Y don't-care mask) into the ordered stream of unicast destination addresses it covers, one per cycle. It sits in front of any cluster-facing port that cannot accept multicast natively, for example a legacy DMA front-end or an endpoint with multicast disabled. It uses the same X/Y mask-field layout as the multicast SAM rules in `picobello_pkg`, so every destination it emits is a cluster tile address.

## Interface
Parameters:
- `AddrWidth`, 48: address and mask width.
- `UserWidth`, 1: opaque sideband carried unchanged with every destination.
- `MaskYOffset`, 18: LSB of the Y field. Equals log2 of the cluster tile size.
- `MaskYLen`, 4: Y field width.
- `MaskXOffset`, 22: LSB of the X field. Must equal `MaskYOffset+MaskYLen`, checked by an elaboration assertion.
- `MaskXLen`, 4: X field width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: synchronous abort of the request in progress.
- `in_valid_i`, in, 1: multicast request valid.
- `in_ready_o`, out, 1: request accepted.
- `in_addr_i`, in, `AddrWidth`: request address.
- `in_mask_i`, in, `AddrWidth`: don't-care mask. A set bit means "all values" for that bit.
- `in_user_i`, in, `UserWidth`: sideband.
- `out_valid_o`, out, 1: destination valid.
- `out_ready_i`, in, 1: destination consumed.
- `out_addr_o`, out, `AddrWidth`: unicast destination address.
- `out_user_o`, out, `UserWidth`: registered copy of `in_user_i`.
- `out_last_o`, out, 1: marks the final destination of the request.
- `out_idx_o`, out, 16: ordinal of the current destination, starting at 0.

## Operation
- Field mask: F = `in_mask_i` restricted to bits `[MaskXOffset+MaskXLen-1 : MaskYOffset]`. Mask bits outside this range are ignored. The matching address bits pass through unchanged.
- Base address: `in_addr_i & ~F`. Destination count: 2^popcount(F).
- Enumeration covers the subsets S of F in ascending numeric order. Next subset: S' = ((S | ~F) + 1) & F, computed over the field width only. Because the X field sits above the Y field, this order is X outer, Y inner. Each output address is base | S.
- Last condition: S == F. When F is 0, exactly one destination is emitted with `out_last_o`=1.
- FSM states:
  - IDLE: `in_ready_o`=1, `out_valid_o`=0. An `in_valid_i` handshake registers base, F, user and S=0, clears the index, and moves to EMIT.
  - EMIT: `in_ready_o`=0, `out_valid_o`=1. On an `out_ready_i` handshake, if S==F go to IDLE. Otherwise advance S and increment the index.
- `flush_i` in EMIT: go to IDLE next cycle and drop the remaining destinations. A handshake in the flush cycle still counts. `flush_i` in IDLE has no effect.
- `out_idx_o` saturates at 0xFFFF. It cannot overflow with the default parameters, where the maximum is 256 destinations.

## Timing
- Reset values: state IDLE, `in_ready_o`=1, `out_valid_o`=0, `out_addr_o`=0, `out_user_o`=0, `out_last_o`=0, `out_idx_o`=0.
- Outputs are registered. The first destination is valid in the cycle after the input handshake.
- With `out_ready_i` held high, one destination is emitted per cycle.
- `in_ready_o` is high in the cycle after the last handshake, so the request-to-request bubble is 1 cycle.
- While `out_valid_o`=1 and `out_ready_i`=0, `out_addr_o`, `out_user_o`, `out_last_o` and `out_idx_o` hold stable.
- An asynchronous reset mid-EMIT returns the block to IDLE immediately and discards the pending request.

## Structure
- `picobello_pkg` carries the field constants, derived from the `mask_sel_t` of cluster rules: `McastFieldOffset` and `McastFieldLen`. The top level passes them into the parameters.
- One combinational sub-module, `pb_mcast_next_subset`: input (S, F), outputs S' and is_last.
- The FSM and registers are in this module.

## Test plan
- Addr 0x2040_0000, mask 0x00C0_0000 -> 0x2000_0000, 0x2040_0000, 0x2080_0000, 0x20C0_0000, `out_last_o` only on the fourth, idx 0..3.
- Addr 0x2000_0000, mask 0x0044_0000 -> 0x2000_0000, 0x2004_0000, 0x2040_0000, 0x2044_0000, in that order.
- Mask 0x0000_0008, addr 0x2000_0008 -> a single destination 0x2000_0008 with `out_last_o`=1. The out-of-field bit is ignored.
- Full mask 0x03FC_0000 with random `out_ready_i` backpressure -> 256 unique addresses, stable while stalled, last on 0x23FC_0000 (base 0x2000_0000).
- `flush_i` asserted after the 2nd handshake of a 4-destination request -> `out_valid_o`=0 next cycle, `in_ready_o`=1. A following request starts again at idx 0.
- `rst_ni` pulsed low mid-EMIT -> all outputs at their reset values immediately. The next request is processed normally.

Source files
------------

// File: rtl/pb_mcast_unroller_pkg.sv
// Shared constants for the multicast unroller: X/Y mask field layout of a cluster
// tile address and the FSM state encoding.
package pb_mcast_unroller_pkg;

    // Field layout matching the multicast SAM rules (Y field below X field)
    localparam int unsigned McastFieldOffset = 18;
    localparam int unsigned McastYLen        = 4;
    localparam int unsigned McastXLen        = 4;
    localparam int unsigned McastFieldLen    = McastYLen + McastXLen;
    localparam int unsigned McastXOffset     = McastFieldOffset + McastYLen;

    localparam int unsigned IdxWidth = 16;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StEmit = 1'b1;

endpackage

// File: rtl/pb_mcast_next_subset.sv
// Next subset of a field mask in ascending numeric order, plus a flag that the
// current subset is the final one (equal to the whole field).
module pb_mcast_next_subset #(
    parameter int unsigned FieldWidth = 8
) (
    input  logic [FieldWidth-1:0] subset,
    input  logic [FieldWidth-1:0] field,
    output logic [FieldWidth-1:0] subset_next_c,
    output logic                  is_last_c
);

    // Filling the non-field bits lets the carry ripple straight to the next field bit
    assign subset_next_c = ((subset | ~field) + FieldWidth'(1)) & field;
    assign is_last_c     = (subset == field);

endmodule

// File: rtl/pb_mcast_unroller.sv
// Expands one multicast request (address + X/Y don't-care mask) into the ordered
// stream of unicast cluster destinations it covers, one per cycle.
module pb_mcast_unroller
    import pb_mcast_unroller_pkg::*;
#(
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned UserWidth   = 1,
    parameter int unsigned MaskYOffset = McastFieldOffset,
    parameter int unsigned MaskYLen    = McastYLen,
    parameter int unsigned MaskXOffset = McastXOffset,
    parameter int unsigned MaskXLen    = McastXLen
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [AddrWidth-1:0] in_mask_i,
    input  logic [UserWidth-1:0] in_user_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [UserWidth-1:0] out_user_o,
    output logic                 out_last_o,
    output logic [IdxWidth-1:0]  out_idx_o
);

    localparam int unsigned FieldLen = MaskYLen + MaskXLen;
    localparam int unsigned FieldLsb = MaskYOffset;
    localparam logic [AddrWidth-1:0] FieldMaskWide =
        AddrWidth'((64'd1 << FieldLen) - 64'd1) << FieldLsb;
    localparam logic [IdxWidth-1:0] IdxMax = '1;

    if (MaskXOffset != MaskYOffset + MaskYLen) begin : g_bad_layout
        $error("pb_mcast_unroller: X field must sit directly above the Y field");
    end

    logic [0:0]           state_q, state_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [FieldLen-1:0]  field_q, field_d;
    logic [FieldLen-1:0]  subset_q, subset_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [UserWidth-1:0] user_q, user_d;
    logic                 last_q, last_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [FieldLen-1:0]  subset_next_c;
    logic                 is_last_c;
    logic [AddrWidth-1:0] in_field_wide;

    pb_mcast_next_subset #(
        .FieldWidth(FieldLen)
    ) i_next_subset (
        .subset        (subset_q),
        .field         (field_q),
        .subset_next_c (subset_next_c),
        .is_last_c     (is_last_c)
    );

    assign in_field_wide = in_mask_i & FieldMaskWide;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        field_d  = field_q;
        subset_d = subset_q;
        addr_d   = addr_q;
        user_d   = user_q;
        last_d   = last_q;
        idx_d    = idx_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    state_d  = StEmit;
                    base_d   = in_addr_i & ~in_field_wide;
                    field_d  = in_field_wide[FieldLsb +: FieldLen];
                    subset_d = '0;
                    addr_d   = in_addr_i & ~in_field_wide;
                    user_d   = in_user_i;
                    last_d   = (in_field_wide == '0);
                    idx_d    = '0;
                end
            end
            StEmit: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (out_ready_i) begin
                    if (is_last_c) begin
                        state_d = StIdle;
                    end else begin
                        subset_d = subset_next_c;
                        addr_d   = base_q | (AddrWidth'(subset_next_c) << FieldLsb);
                        last_d   = (subset_next_c == field_q);
                        idx_d    = (idx_q == IdxMax) ? idx_q : idx_q + IdxWidth'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StEmit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            base_q      <= '0;
            field_q     <= '0;
            subset_q    <= '0;
            addr_q      <= '0;
            user_q      <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            field_q     <= field_d;
            subset_q    <= subset_d;
            addr_q      <= addr_d;
            user_q      <= user_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = addr_q;
    assign out_user_o  = user_q;
    assign out_last_o  = last_q;
    assign out_idx_o   = idx_q;

endmodule

// File: tb/tb_pb_mcast_unroller.sv
// Randomized bench for pb_mcast_unroller: a subset-enumeration model expands each
// accepted request and a negedge compare process checks every output cycle.
module tb_pb_mcast_unroller;

    localparam logic [47:0] FieldMask = 48'h0000_03FC_0000;

    typedef struct packed {
        logic [47:0] addr;
        logic        user;
        logic        last;
        logic [15:0] idx;
    } exp_t;
    typedef exp_t exp_list_t[$];

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_addr = '0;
    logic [47:0] in_mask = '0;
    logic [0:0]  in_user = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_addr;
    logic [0:0]  out_user;
    logic        out_last;
    logic [15:0] out_idx;

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    exp_t exp_q[$];

    pb_mcast_unroller dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_addr_i   (in_addr),
        .in_mask_i   (in_mask),
        .in_user_i   (in_user),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_addr_o  (out_addr),
        .out_user_o  (out_user),
        .out_last_o  (out_last),
        .out_idx_o   (out_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every field value whose bits lie inside F, ascending, OR-ed onto the base
    function automatic exp_list_t expand(input logic [47:0] addr, input logic [47:0] mask,
                                         input logic user);
        exp_list_t l;
        logic [47:0] f;
        logic [47:0] sub;
        exp_t e;
        f = mask & FieldMask;
        for (int v = 0; v < 256; v++) begin
            sub = 48'(v) << 18;
            if ((sub & ~f) == '0) begin
                e.addr = (addr & ~f) | sub;
                e.user = user;
                e.last = 1'b0;
                e.idx  = 16'(l.size());
                l.push_back(e);
            end
        end
        l[l.size()-1].last = 1'b1;
        return l;
    endfunction

    // Compare process: one evaluation per cycle, away from the active edge
    always @(negedge clk) begin
        exp_list_t nl;
        bit busy;
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            busy = (exp_q.size() != 0);
            check("out_valid", 64'(out_valid), 64'(busy));
            check("in_ready", 64'(in_ready), 64'(!busy));
            if (busy && out_valid) begin
                check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                check("out_user", 64'(out_user), 64'(exp_q[0].user));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
                check("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
            end
            if (busy && out_ready) void'(exp_q.pop_front());
            if (busy && flush) exp_q.delete();
            if (!busy && in_valid) begin
                nl = expand(in_addr, in_mask, in_user[0]);
                foreach (nl[i]) exp_q.push_back(nl[i]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic send_req(input logic [47:0] a, input logic [47:0] m, input logic u);
        int n = 0;
        in_addr  = a;
        in_mask  = m;
        in_user  = u;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_addr"}, 64'(out_addr), 64'd0);
        check({tag, "_user"}, 64'(out_user), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_idx"}, 64'(out_idx), 64'd0);
    endtask

    initial begin
        exp_list_t l;
        logic [47:0] lit1 [4];
        logic [47:0] lit2 [4];
        bit ascending;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #2 rst_ni = 1'b1;

        // Pin the model with hand-computed expansions
        lit1 = '{48'h2000_0000, 48'h2040_0000, 48'h2080_0000, 48'h20C0_0000};
        lit2 = '{48'h2000_0000, 48'h2004_0000, 48'h2040_0000, 48'h2044_0000};
        l = expand(48'h2040_0000, 48'h00C0_0000, 1'b0);
        check("model1_size", 64'(l.size()), 64'd4);
        foreach (lit1[i]) begin
            check("model1_addr", 64'(l[i].addr), 64'(lit1[i]));
            check("model1_last", 64'(l[i].last), 64'(i == 3));
        end
        l = expand(48'h2000_0000, 48'h0044_0000, 1'b0);
        foreach (lit2[i]) check("model2_addr", 64'(l[i].addr), 64'(lit2[i]));
        l = expand(48'h2000_0008, 48'h0000_0008, 1'b0);
        check("model3_size", 64'(l.size()), 64'd1);
        check("model3_addr", 64'(l[0].addr), 64'h2000_0008);
        l = expand(48'h2000_0000, 48'h03FC_0000, 1'b0);
        check("model4_size", 64'(l.size()), 64'd256);
        check("model4_lastaddr", 64'(l[255].addr), 64'h23FC_0000);
        ascending = 1'b1;
        for (int i = 1; i < l.size(); i++) if (l[i].addr <= l[i-1].addr) ascending = 1'b0;
        check("model4_unique", 64'(ascending), 64'd1);

        // Directed requests through the DUT
        @(posedge clk);
        #1;
        send_req(48'h2040_0000, 48'h00C0_0000, 1'b1);
        wait_idle();
        send_req(48'h2000_0000, 48'h0044_0000, 1'b0);
        wait_idle();
        send_req(48'h2000_0008, 48'h0000_0008, 1'b1);
        wait_idle();
        ready_pct = 50;
        send_req(48'h2000_0000, 48'h03FC_0000, 1'b1);
        wait_idle();

        // Flush after the second handshake of a 4-destination request
        ready_pct = 100;
        @(posedge clk);
        #1;
        send_req(48'h2040_0000, 48'h00C0_0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        send_req(48'h2000_0000, 48'h0044_0000, 1'b1);
        wait_idle();

        // Asynchronous reset in the middle of a long request
        @(posedge clk);
        #1;
        send_req(48'h2000_0000, 48'h03FC_0000, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        send_req(48'h2040_0000, 48'h00C0_0000, 1'b1);
        wait_idle();

        // Random traffic with backpressure
        ready_pct = 70;
        for (int r = 0; r < 25; r++) begin
            @(posedge clk);
            #1;
            send_req({16'($urandom), $urandom}, {16'($urandom), $urandom & $urandom},
                     1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
